// File: rtl/div_iter_unit.sv
// div_iter_unit: sequential signed restoring divider for the multdiv path.
// One quotient bit is produced per cycle from a {remainder, quotient}
// working register. Operands are reduced to magnitudes on start, and the
// sign is reapplied when the quotient is written back. The remainder never
// leaves the block.
module div_iter_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             ctrl_reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_ERR
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   work_q;
  logic [2*WIDTH-1:0]   work_d;
  logic [WIDTH-1:0]     dvsr_q;
  logic                 sign_q;
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q;
  logic                 rdy_q;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   shifted;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     quot;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    a_mag = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
    b_mag = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;
  end

  // One restoring step: shift, trial-subtract the divisor from the upper
  // half, keep the difference and set the quotient bit if it did not borrow.
  always_comb begin
    shifted = {work_q[2*WIDTH-2:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dvsr_q};
    work_d  = shifted;
    if (!diff[WIDTH]) begin
      work_d = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end
    quot = work_q[WIDTH-1:0];
  end

  // Control FSM and datapath registers; a start pulse restarts from any state.
  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (ctrl_DIV) begin
      sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      work_q  <= {{WIDTH{1'b0}}, a_mag};
      dvsr_q  <= b_mag;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      state_q <= (data_operandB == '0) ? S_ERR : S_RUN;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q <= S_IDLE;
        end
        S_RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= sign_q ? ('0 - quot) : quot;
          exc_q    <= 1'b0;
          rdy_q    <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_ERR: begin
          result_q <= '0;
          exc_q    <= 1'b1;
          rdy_q    <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: scoreboard bench for div_iter_unit. Stimulus pushes the
// expected quotient, exception flag and completion cycle; a monitor pops and
// compares on every completion pulse.
module tb_div_iter_unit;

  logic        clk;
  logic        ctrl_reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  div_iter_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk            (clk),
    .ctrl_reset     (ctrl_reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: signed division truncating toward zero, done in 64-bit
  // arithmetic and wrapped back to 32 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned e0);
    exp_t   e;
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
      e.due = e0 + 1;
    end else begin
      q     = sa / sb;
      e.res = q[31:0];
      e.exc = 1'b0;
      e.due = e0 + 33;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue one start pulse; any op still pending is aborted by it.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    sbq.delete();
    sbq.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no completion within %0d cycles", n);
      sbq.delete();
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (data_resultRDY === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: pulse at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("latency", cyc, e.due);
      end
    end
  end

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    checks        = 0;
    errors        = 0;
    ctrl_reset    = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clk);
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    ctrl_reset = 1'b0;

    // Directed cases
    start(32'd100, 32'd7);               wait_done();
    start(32'hFFFFFF9C, 32'd7);          wait_done();
    start(32'hFFFFFF9C, 32'hFFFFFFF9);   wait_done();
    start(32'd7, 32'd100);               wait_done();
    start(32'd5, 32'd0);                 wait_done();
    start(32'd9, 32'd3);                 wait_done();
    start(32'h80000000, 32'hFFFFFFFF);   wait_done();
    start(32'h80000000, 32'd2);          wait_done();
    start(32'h80000000, 32'h80000000);   wait_done();
    start(32'h7FFFFFFF, 32'd1);          wait_done();

    // Data outputs hold after the pulse
    repeat (3) @(negedge clk);
    check("hold_result", data_result, 32'h7FFFFFFF);

    // Restart mid-run: only the second op may complete
    start(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    start(32'd50, 32'd5);
    wait_done();

    // Restart on the final-iteration window
    start(32'd1000, 32'd10);
    repeat (31) @(negedge clk);
    start(32'hFFFFFFEC, 32'd4);
    wait_done();

    // Reset mid-run: no pulse, outputs cleared, then a clean op
    start(32'd100, 32'd7);
    repeat (18) @(negedge clk);
    ctrl_reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    ctrl_reset = 1'b0;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exc", {31'd0, data_exception}, 32'd0);
    repeat (40) @(negedge clk);
    start(32'd9, 32'd3);
    wait_done();

    // Reset wins over a simultaneous start
    @(negedge clk);
    ctrl_reset    = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd0;
    @(negedge clk);
    ctrl_reset = 1'b0;
    ctrl_DIV   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_beats_start", {31'd0, data_exception}, 32'd0);

    // Random operands, with zero and small divisors mixed in
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'd0 - $urandom_range(1, 15);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200);
      start(ra, rb);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
